// File: rtl/seq_scan_ctrl.sv
// Round-robin scheduler that shares one serial sequence detector between two requesters.
// It shifts each granted word into the detector MSB-first and counts the detector's z pulses.
//   state  | meaning
//   IDLE   | arbitrate; grant latches word and id
//   CLR    | detector held in reset, bit index loaded
//   SHIFT  | one bit per cycle to det_x, count det_z
//   REPORT | done strobe with final count and id
module seq_scan_ctrl #(
  parameter int WIDTH = 8,
  parameter int CW    = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0,
  input  logic [WIDTH-1:0] data0,
  input  logic             req1,
  input  logic [WIDTH-1:0] data1,
  output logic             gnt0,
  output logic             gnt1,
  output logic             det_rst,
  output logic             det_x,
  input  logic             det_z,
  output logic             busy,
  output logic             done,
  output logic             done_id,
  output logic [CW-1:0]    hit_cnt
);

  localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, CLR, SHIFT, REPORT} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] sh_q, sh_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [CW-1:0]    hit_q, hit_d;
  logic             id_q, id_d;
  logic             last_q, last_d;
  logic             done_id_q, done_id_d;
  logic             pick1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      sh_q      <= '0;
      idx_q     <= '0;
      cnt_q     <= '0;
      hit_q     <= '0;
      id_q      <= 1'b0;
      last_q    <= 1'b1;
      done_id_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      sh_q      <= sh_d;
      idx_q     <= idx_d;
      cnt_q     <= cnt_d;
      hit_q     <= hit_d;
      id_q      <= id_d;
      last_q    <= last_d;
      done_id_q <= done_id_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    sh_d      = sh_q;
    idx_d     = idx_q;
    cnt_d     = cnt_q;
    hit_d     = hit_q;
    id_d      = id_q;
    last_d    = last_q;
    done_id_d = done_id_q;
    gnt0      = 1'b0;
    gnt1      = 1'b0;
    det_x     = 1'b0;
    done      = 1'b0;
    // On contention the requester not served last wins.
    pick1     = req1 & (~req0 | ~last_q);
    case (state_q)
      IDLE: begin
        if (!reset && (req0 || req1)) begin
          gnt0    = ~pick1;
          gnt1    = pick1;
          sh_d    = pick1 ? data1 : data0;
          id_d    = pick1;
          cnt_d   = '0;
          state_d = CLR;
        end
      end
      CLR: begin
        idx_d   = IW'(WIDTH - 1);
        state_d = SHIFT;
      end
      SHIFT: begin
        det_x = sh_q[WIDTH-1];
        sh_d  = {sh_q[WIDTH-2:0], 1'b0};
        if (det_z && (cnt_q != '1)) cnt_d = cnt_q + 1'b1;
        if (idx_q == '0) begin
          // Capture the result now so it is already valid during REPORT.
          hit_d     = cnt_d;
          done_id_d = id_q;
          state_d   = REPORT;
        end else begin
          idx_d = idx_q - 1'b1;
        end
      end
      REPORT: begin
        done    = 1'b1;
        last_d  = id_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy    = (state_q != IDLE);
  assign det_rst = reset | (state_q == CLR);
  assign hit_cnt = hit_q;
  assign done_id = done_id_q;

endmodule

// File: tb/tb_seq_scan_ctrl.sv
// Directed bench for seq_scan_ctrl: detector stubbed as det_z=det_x, results checked via a scoreboard.
module tb_seq_scan_ctrl;

  logic       clk, reset;
  logic       req0, req1, gnt0, gnt1, det_rst, det_x, det_z, busy, done, done_id;
  logic [7:0] data0, data1;
  logic [3:0] hit_cnt;
  logic       z_mode;

  logic       req0_b, gnt0_b, gnt1_b, det_rst_b, det_x_b, busy_b, done_b, done_id_b;
  logic [7:0] data0_b;
  logic [2:0] hit_cnt_b;

  typedef struct packed {logic id; logic [3:0] cnt;} exp_t;
  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;

  seq_scan_ctrl #(.WIDTH(8), .CW(4)) dut (
    .clk(clk), .reset(reset), .req0(req0), .data0(data0), .req1(req1), .data1(data1),
    .gnt0(gnt0), .gnt1(gnt1), .det_rst(det_rst), .det_x(det_x), .det_z(det_z),
    .busy(busy), .done(done), .done_id(done_id), .hit_cnt(hit_cnt));

  seq_scan_ctrl #(.WIDTH(8), .CW(3)) dut_sat (
    .clk(clk), .reset(reset), .req0(req0_b), .data0(data0_b), .req1(1'b0), .data1(8'h00),
    .gnt0(gnt0_b), .gnt1(gnt1_b), .det_rst(det_rst_b), .det_x(det_x_b), .det_z(det_x_b),
    .busy(busy_b), .done(done_b), .done_id(done_id_b), .hit_cnt(hit_cnt_b));

  // Stub mode 1: z is 1 everywhere except SHIFT, where it is 0.
  assign det_z = z_mode ? ~(busy & ~det_rst & ~done) : det_x;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (done === 1'b1 && reset === 1'b0) begin
      exp_t e;
      n_cmp++;
      assert (sb.size() != 0) else begin
        n_err++;
        $error("FAIL unexpected_done: observed done=1 expected no pending scan");
      end
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("sb_hit_cnt", 32'(hit_cnt), 32'(e.cnt));
        chk("sb_done_id", 32'(done_id), 32'(e.id));
      end
    end
  end

  // Called at the negedge of the grant cycle with the request already driven.
  task automatic run_scan(input bit id, input bit drop, input int pulse_at);
    logic [7:0] w;
    w = id ? data1 : data0;
    #1;
    chk("gnt0", 32'(gnt0), 32'(!id));
    chk("gnt1", 32'(gnt1), 32'(id));
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      chk("busy", 32'(busy), 1);
      chk("gnt0_busy", 32'(gnt0), 0);
      chk("gnt1_busy", 32'(gnt1), 0);
      chk("done_cycle", 32'(done), (c == 10) ? 1 : 0);
      if (c == 1) begin
        chk("det_rst_clr", 32'(det_rst), 1);
        chk("det_x_clr", 32'(det_x), 0);
      end else if (c <= 9) begin
        chk("det_x_bit", 32'(det_x), 32'(w[9-c]));
        chk("det_rst_shift", 32'(det_rst), 0);
      end else begin
        chk("det_x_report", 32'(det_x), 0);
      end
      if (drop && c == 1) begin
        if (id) req1 = 1'b0; else req0 = 1'b0;
      end
      if (c == pulse_at) req1 = 1'b1;
      if (c == pulse_at + 1) req1 = 1'b0;
    end
  endtask

  initial begin
    reset = 1'b1; req0 = 0; req1 = 0; data0 = 0; data1 = 0; z_mode = 0;
    req0_b = 0; data0_b = 0;
    repeat (2) @(negedge clk);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_det_x", 32'(det_x), 0);
    chk("rst_det_rst", 32'(det_rst), 1);
    chk("rst_hit_cnt", 32'(hit_cnt), 0);
    chk("rst_done_id", 32'(done_id), 0);
    chk("rst_gnt0", 32'(gnt0), 0);
    reset = 1'b0;
    @(negedge clk);

    // Single scan of A5 from requester 0.
    data0 = 8'hA5; req0 = 1'b1;
    sb.push_back('{id: 1'b0, cnt: 4'd4});
    run_scan(1'b0, 1'b1, -10);
    @(negedge clk);
    chk("idle_after_done", 32'(busy), 0);
    chk("hit_cnt_hold", 32'(hit_cnt), 4);

    // Contention held from reset: order 0,1,0.
    reset = 1'b1;
    data0 = 8'hFF; data1 = 8'h01; req0 = 1'b1; req1 = 1'b1;
    #1;
    chk("rst_no_gnt0", 32'(gnt0), 0);
    chk("rst_no_gnt1", 32'(gnt1), 0);
    @(negedge clk);
    reset = 1'b0;
    sb.push_back('{id: 1'b0, cnt: 4'd8});
    sb.push_back('{id: 1'b1, cnt: 4'd1});
    sb.push_back('{id: 1'b0, cnt: 4'd8});
    for (int s = 0; s < 3; s++) begin
      run_scan(s[0], 1'b0, -10);
      @(negedge clk);
    end
    req0 = 1'b0; req1 = 1'b0;
    #1;
    chk("cont_end_gnt0", 32'(gnt0), 0);
    chk("cont_end_gnt1", 32'(gnt1), 0);
    @(negedge clk);

    // Saturation on the CW=3 instance.
    data0_b = 8'hFF; req0_b = 1'b1;
    #1;
    chk("sat_gnt0", 32'(gnt0_b), 1);
    @(negedge clk);
    req0_b = 1'b0;
    repeat (9) @(negedge clk);
    chk("sat_done", 32'(done_b), 1);
    chk("sat_hit_cnt", 32'(hit_cnt_b), 7);
    @(negedge clk);

    // Reset during the 4th SHIFT cycle aborts the scan.
    data1 = 8'hF0; req1 = 1'b1;
    #1;
    chk("abort_gnt1", 32'(gnt1), 1);
    @(negedge clk);
    req1 = 1'b0;
    repeat (4) @(negedge clk);
    reset = 1'b1;
    #1;
    chk("abort_busy", 32'(busy), 0);
    chk("abort_det_rst", 32'(det_rst), 1);
    chk("abort_done", 32'(done), 0);
    chk("abort_det_x", 32'(det_x), 0);
    repeat (2) begin
      @(negedge clk);
      chk("abort_done_hold", 32'(done), 0);
      chk("abort_busy_hold", 32'(busy), 0);
    end
    reset = 1'b0;
    @(negedge clk);
    chk("abort_hit_cnt", 32'(hit_cnt), 0);
    data1 = 8'h0F; req1 = 1'b1;
    sb.push_back('{id: 1'b1, cnt: 4'd4});
    run_scan(1'b1, 1'b1, -10);
    @(negedge clk);

    // z high outside SHIFT and low inside must count nothing.
    z_mode = 1'b1;
    @(negedge clk);
    data0 = 8'hFF; req0 = 1'b1;
    sb.push_back('{id: 1'b0, cnt: 4'd0});
    run_scan(1'b0, 1'b1, -10);
    @(negedge clk);
    z_mode = 1'b0;

    // req1 pulsed while busy is never granted.
    data0 = 8'h3C; req0 = 1'b1;
    sb.push_back('{id: 1'b0, cnt: 4'd4});
    run_scan(1'b0, 1'b1, 4);
    repeat (3) begin
      @(negedge clk);
      chk("pulse_no_gnt1", 32'(gnt1), 0);
      chk("pulse_idle", 32'(busy), 0);
    end

    chk("sb_empty", 32'(sb.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
